// File: rtl/multi_loop_counter.sv
// Multi-channel step-synchronised loop counter.
// Each channel latches a loop count on its start strobe, counts shared
// sequencer step edges through a fixed steps-per-loop pattern and holds
// Play high until the requested loops have finished (0 = run forever).
// Optional macro LOOP_REMAIN_EN adds a registered per-channel Remain output.

module multi_loop_counter_ch #(
  parameter int LOOP_W         = 7,
  parameter int STEPS_PER_LOOP = 12,
  parameter int STEP_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_rise,
  input  logic              start_n,
  input  logic              stop_n,
  input  logic [LOOP_W-1:0] loops_in,
  output logic              play,
  output logic [STEP_W-1:0] step_idx,
  output logic [LOOP_W-1:0] loop_idx,
  output logic              done
`ifdef LOOP_REMAIN_EN
  , output logic [LOOP_W-1:0] remain
`endif
);

  typedef enum logic [1:0] {IDLE, RUN_FIN, RUN_INF} state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS_PER_LOOP - 1);

  state_t            state, state_d;
  logic [LOOP_W-1:0] loops_q, loops_d;
  logic [STEP_W-1:0] step_d;
  logic [LOOP_W-1:0] loop_d;
  logic              play_d, done_d;
  logic              finish;
`ifdef LOOP_REMAIN_EN
  logic [LOOP_W-1:0] remain_d;
`endif

  // The finishing rise is the one after the last loop wrapped back to step 0.
  assign finish = (state == RUN_FIN) && (loop_idx == loops_q) && (step_idx == '0);

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      loops_q  <= '0;
      step_idx <= '0;
      loop_idx <= '0;
      play     <= 1'b0;
      done     <= 1'b0;
`ifdef LOOP_REMAIN_EN
      remain   <= '0;
`endif
    end else begin
      state    <= state_d;
      loops_q  <= loops_d;
      step_idx <= step_d;
      loop_idx <= loop_d;
      play     <= play_d;
      done     <= done_d;
`ifdef LOOP_REMAIN_EN
      remain   <= remain_d;
`endif
    end
  end

  // Next state: start beats stop beats step.
  always_comb begin
    state_d = state;
    if (!start_n)
      state_d = (loops_in == '0) ? RUN_INF : RUN_FIN;
    else if (!stop_n)
      state_d = IDLE;
    else if (step_rise && finish)
      state_d = IDLE;
  end

  // Next values of the registered outputs; counters hold when leaving a run.
  always_comb begin
    loops_d = loops_q;
    step_d  = step_idx;
    loop_d  = loop_idx;
    done_d  = 1'b0;
    if (!start_n) begin
      loops_d = loops_in;
      step_d  = '0;
      loop_d  = '0;
    end else if (!stop_n) begin
      done_d = (state != IDLE);
    end else if (step_rise && state != IDLE) begin
      if (finish)
        done_d = 1'b1;
      else if (step_idx == LAST_STEP) begin
        step_d = '0;
        loop_d = loop_idx + 1'b1;
      end else
        step_d = step_idx + 1'b1;
    end
    play_d = (state_d != IDLE);
`ifdef LOOP_REMAIN_EN
    remain_d = (state_d == RUN_FIN) ? (loops_d - loop_d) : '0;
`endif
  end

endmodule

module multi_loop_counter #(
  parameter int CHANNELS       = 4,
  parameter int LOOP_W         = 7,
  parameter int STEPS_PER_LOOP = 12,
  parameter int STEP_W         = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Step,
  input  logic [CHANNELS-1:0]        nStart,
  input  logic [CHANNELS-1:0]        nStop,
  input  logic [CHANNELS*LOOP_W-1:0] Loops,
  output logic [CHANNELS-1:0]        Play,
  output logic [CHANNELS*STEP_W-1:0] StepIdx,
  output logic [CHANNELS*LOOP_W-1:0] LoopIdx,
  output logic [CHANNELS-1:0]        Done
`ifdef LOOP_REMAIN_EN
  , output logic [CHANNELS*LOOP_W-1:0] Remain
`endif
);

  logic sync1, sync2;
  logic step_rise;

  // Two-flop synchroniser for the asynchronous Step level, shared by all channels.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= Step;
      sync2 <= sync1;
    end
  end

  assign step_rise = sync1 & ~sync2;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    multi_loop_counter_ch #(
      .LOOP_W         (LOOP_W),
      .STEPS_PER_LOOP (STEPS_PER_LOOP),
      .STEP_W         (STEP_W)
    ) u_ch (
      .clk       (Clock),
      .rst       (Reset),
      .step_rise (step_rise),
      .start_n   (nStart[c]),
      .stop_n    (nStop[c]),
      .loops_in  (Loops[c*LOOP_W +: LOOP_W]),
      .play      (Play[c]),
      .step_idx  (StepIdx[c*STEP_W +: STEP_W]),
      .loop_idx  (LoopIdx[c*LOOP_W +: LOOP_W]),
      .done      (Done[c])
`ifdef LOOP_REMAIN_EN
      , .remain  (Remain[c*LOOP_W +: LOOP_W])
`endif
    );
  end

endmodule

// File: tb/tb_multi_loop_counter.sv
// Directed bench for multi_loop_counter (default parameters).
module tb_multi_loop_counter;
  localparam int CH = 4, LW = 7, SPL = 12, SW = 4;

  logic          Clock = 1'b0, Reset = 1'b1, Step = 1'b0;
  logic [CH-1:0] nStart = '1, nStop = '1;
  logic [CH*LW-1:0] Loops = '0;
  logic [CH-1:0] Play, Done;
  logic [CH*SW-1:0] StepIdx;
  logic [CH*LW-1:0] LoopIdx;
`ifdef LOOP_REMAIN_EN
  logic [CH*LW-1:0] Remain;
`endif

  int ncmp = 0, nerr = 0;
  int done1_cnt = 0;
  bit seen_done2 = 1'b0;

  multi_loop_counter #(.CHANNELS(CH), .LOOP_W(LW), .STEPS_PER_LOOP(SPL), .STEP_W(SW)) dut (
    .Clock(Clock), .Reset(Reset), .Step(Step), .nStart(nStart), .nStop(nStop),
    .Loops(Loops), .Play(Play), .StepIdx(StepIdx), .LoopIdx(LoopIdx), .Done(Done)
`ifdef LOOP_REMAIN_EN
    , .Remain(Remain)
`endif
  );

  always #5 Clock = ~Clock;

  // Done monitors, sampled away from the active edge.
  always @(negedge Clock) begin
    if (!Reset && Done[1]) done1_cnt++;
    if (!Reset && Done[2]) seen_done2 = 1'b1;
  end

  function automatic logic [31:0] sidx(int c);
    return 32'(StepIdx[c*SW +: SW]);
  endfunction
  function automatic logic [31:0] lidx(int c);
    return 32'(LoopIdx[c*LW +: LW]);
  endfunction
`ifdef LOOP_REMAIN_EN
  function automatic logic [31:0] ridx(int c);
    return 32'(Remain[c*LW +: LW]);
  endfunction
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full Step pulse; returns at posedge+1 after the rise has been applied.
  task automatic step_edge();
    Step = 1'b1;
    repeat (3) @(posedge Clock);
    #1 Step = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_play", 32'(Play), 0);
    check("rst_step", 32'(StepIdx), 0);
    check("rst_loop", 32'(LoopIdx), 0);
    check("rst_done", 32'(Done), 0);
    @(posedge Clock); #1 Reset = 1'b0;
    @(posedge Clock); #1;

    // Channel 0 Loops=3, run to StepIdx=5, then asynchronous reset mid-run
    Loops[0*LW +: LW] = 7'd3;
    nStart[0] = 1'b0;
    @(posedge Clock); #1 nStart[0] = 1'b1;
    check("c0_play_start", 32'(Play[0]), 1);
    repeat (5) step_edge();
    check("c0_step5", sidx(0), 5);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_play", 32'(Play), 0);
    check("async_rst_step", 32'(StepIdx), 0);
    check("async_rst_loop", 32'(LoopIdx), 0);
    @(posedge Clock); #1 Reset = 1'b0;
    step_edge();
    check("post_rst_idle_play", 32'(Play[0]), 0);
    check("post_rst_idle_step", sidx(0), 0);

    // Channels 1 (Loops=2) and 3 (Loops=5) start together
    Loops[1*LW +: LW] = 7'd2;
    Loops[3*LW +: LW] = 7'd5;
    Loops[0*LW +: LW] = 7'd0;
    nStart[1] = 1'b0; nStart[3] = 1'b0;
    @(posedge Clock); #1 nStart[1] = 1'b1; nStart[3] = 1'b1;
    check("c1c3_play", 32'(Play), 32'b1010);
`ifdef LOOP_REMAIN_EN
    check("c1_remain_start", ridx(1), 2);
`endif
    repeat (7) step_edge();
    check("c3_step7", sidx(3), 7);
    check("c3_play_run", 32'(Play[3]), 1);
    // Stop channel 3; start channel 0 (infinite) right after
    nStop[3] = 1'b0;
    @(posedge Clock); #1 nStop[3] = 1'b1;
    check("c3_stop_done", 32'(Done[3]), 1);
    check("c3_stop_play", 32'(Play[3]), 0);
    check("c3_stop_step", sidx(3), 7);
    nStart[0] = 1'b0;
    @(posedge Clock); #1 nStart[0] = 1'b1;
    check("c3_done_1cyc", 32'(Done[3]), 0);
    // Rises 8..24
    repeat (12 - 7) step_edge();
`ifdef LOOP_REMAIN_EN
    check("c1_remain_l1", ridx(1), 1);
`endif
    repeat (24 - 12) step_edge();
    check("c1_play_24", 32'(Play[1]), 1);
    check("c1_step_24", sidx(1), 0);
    check("c1_loop_24", lidx(1), 2);
`ifdef LOOP_REMAIN_EN
    check("c1_remain_l2", ridx(1), 0);
`endif
    check("c3_hold_step", sidx(3), 7);
    check("c3_hold_play", 32'(Play[3]), 0);
    check("c0_step_17", sidx(0), 5);
    check("c0_loop_17", lidx(0), 1);
    check("c1_no_done_yet", 32'(done1_cnt), 0);

    // Rise 25: channel 1 completes while channel 0 reloads on the same rise
    nStart[0] = 1'b0;
    Step = 1'b1;
    @(posedge Clock);
    @(posedge Clock); #1;
    check("c1_done_25", 32'(Done[1]), 1);
    check("c1_play_25", 32'(Play[1]), 0);
    check("c1_loop_held", lidx(1), 2);
    check("c1_step_held", sidx(1), 0);
    check("c0_reload_step", sidx(0), 0);
    check("c0_reload_loop", lidx(0), 0);
    check("c0_reload_play", 32'(Play[0]), 1);
`ifdef LOOP_REMAIN_EN
    check("c1_remain_done", ridx(1), 0);
`endif
    nStart[0] = 1'b1;
    @(posedge Clock); #1;
    check("c1_done_gone", 32'(Done[1]), 0);
    check("c0_no_incr", sidx(0), 0);
    Step = 1'b0;
    repeat (3) @(posedge Clock); #1;

    // nStop on idle channel 1: no Done pulse
    nStop[1] = 1'b0;
    @(posedge Clock); #1 nStop[1] = 1'b1;
    check("c1_idle_stop_done", 32'(Done[1]), 0);

    // Channel 2 infinite: first of 30 edges lands while nStart is held low
    Loops[2*LW +: LW] = 7'd0;
    nStart[2] = 1'b0;
    @(posedge Clock); #1 Step = 1'b1;
    repeat (3) @(posedge Clock); #1;
    nStart[2] = 1'b1;
    check("c2_start_rise_ign", sidx(2), 0);
    Step = 1'b0;
    repeat (3) @(posedge Clock); #1;
    repeat (29) step_edge();
    check("c2_play", 32'(Play[2]), 1);
    check("c2_step", sidx(2), 5);
    check("c2_loop", lidx(2), 2);
    check("c2_never_done", 32'(seen_done2), 0);
    check("c1_idle_hold_step", sidx(1), 0);
    check("c1_idle_hold_loop", lidx(1), 2);
    check("c1_done_once", 32'(done1_cnt), 1);
    check("c3_idle_hold", sidx(3), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
